// File: rtl/lcd_hd44780_driver.sv
// HD44780 character-LCD driver: runs the power-on init sequence, then
// executes single commands over a CMD_VALID/RDY handshake on an 8-bit
// or 4-bit (two-nibble) bus. All delays are derived from CLK_HZ.
module lcd_hd44780_driver #(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned BUS_WIDTH = 8,
    parameter int unsigned LINES     = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CMD_VALID,
    input  logic [3:0] OP,
    input  logic [7:0] DATA,
    output logic       RDY,
    output logic       ERR,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_E,
    output logic [7:0] LCD_DB
);

    typedef enum logic [2:0] {
        INIT_WAIT, IDLE, XFER_SETUP, XFER_STROBE, XFER_GAP, EXEC_WAIT
    } state_t;

    typedef struct packed {
        logic        nib;
        logic [7:0]  code;
        logic [31:0] wait_cyc;
    } init_item_t;

    function automatic logic [31:0] ns_to_cyc(input logic [63:0] t_ns);
        logic [63:0] c;
        c = (t_ns * 64'(CLK_HZ) + 64'd999_999_999) / 64'd1_000_000_000;
        if (c == 64'd0) c = 64'd1;
        return 32'(c);
    endfunction

    localparam logic [31:0] T_E     = ns_to_cyc(64'd250);
    localparam logic [31:0] T_NIB   = ns_to_cyc(64'd1_000);
    localparam logic [31:0] T_CMD   = ns_to_cyc(64'd42_000);
    localparam logic [31:0] T_100   = ns_to_cyc(64'd100_000);
    localparam logic [31:0] T_LONG  = ns_to_cyc(64'd1_640_000);
    localparam logic [31:0] T_INIT1 = ns_to_cyc(64'd4_100_000);
    localparam logic [31:0] T_PWR   = ns_to_cyc(64'd15_000_000);
    localparam logic [31:0] T_MS    = ns_to_cyc(64'd1_000_000);

    localparam bit         NIBBLE_BUS = (BUS_WIDTH == 4);
    localparam logic [7:0] FUNC_SET   = NIBBLE_BUS ? ((LINES == 2) ? 8'h28 : 8'h20)
                                                   : ((LINES == 2) ? 8'h38 : 8'h30);
    localparam logic [3:0] INIT_LAST  = NIBBLE_BUS ? 4'd7 : 4'd6;

    // Init step table; single nibbles are stored in the upper half of code.
    function automatic init_item_t init_item(input logic [3:0] step);
        init_item_t it;
        it = '{1'b0, 8'h06, T_CMD};
        if (NIBBLE_BUS) begin
            case (step)
                4'd0:    it = '{1'b1, 8'h30, T_INIT1};
                4'd1:    it = '{1'b1, 8'h30, T_100};
                4'd2:    it = '{1'b1, 8'h30, T_CMD};
                4'd3:    it = '{1'b1, 8'h20, T_CMD};
                4'd4:    it = '{1'b0, FUNC_SET, T_CMD};
                4'd5:    it = '{1'b0, 8'h0C, T_CMD};
                4'd6:    it = '{1'b0, 8'h01, T_LONG};
                default: it = '{1'b0, 8'h06, T_CMD};
            endcase
        end else begin
            case (step)
                4'd0:    it = '{1'b0, FUNC_SET, T_INIT1};
                4'd1:    it = '{1'b0, FUNC_SET, T_100};
                4'd2:    it = '{1'b0, FUNC_SET, T_CMD};
                4'd3:    it = '{1'b0, FUNC_SET, T_CMD};
                4'd4:    it = '{1'b0, 8'h0C, T_CMD};
                4'd5:    it = '{1'b0, 8'h01, T_LONG};
                default: it = '{1'b0, 8'h06, T_CMD};
            endcase
        end
        return it;
    endfunction

    function automatic logic [7:0] bus_first(input logic [7:0] code);
        return NIBBLE_BUS ? {code[7:4], 4'h0} : code;
    endfunction

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d, wait_q, wait_d;
    logic [3:0]  step_q, step_d;
    logic [7:0]  code_q, code_d, db_q, db_d;
    logic        init_q, init_d, nib_q, nib_d, half_q, half_d;
    logic        rdy_q, rdy_d, err_q, err_d, rs_q, rs_d, e_q, e_d;

    logic        start;
    logic [7:0]  x_code;
    logic        x_rs, x_nib;
    logic [31:0] x_wait, op4_cyc;
    logic [3:0]  next_idx;
    init_item_t  item;

    // Next-state logic: one down-counter times every delay; a shared
    // start block loads a transfer for both init steps and commands.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wait_d   = wait_q;
        step_d   = step_q;
        code_d   = code_q;
        db_d     = db_q;
        init_d   = init_q;
        nib_d    = nib_q;
        half_d   = half_q;
        rdy_d    = rdy_q;
        err_d    = 1'b0;
        rs_d     = rs_q;
        e_d      = e_q;
        next_idx = (state_q == INIT_WAIT) ? 4'd0 : step_q + 4'd1;
        item     = init_item(next_idx);
        start    = 1'b0;
        x_code   = item.code;
        x_rs     = 1'b0;
        x_nib    = item.nib;
        x_wait   = item.wait_cyc;
        op4_cyc  = 32'(DATA) * T_MS;

        case (state_q)
            INIT_WAIT: begin
                if (cnt_q == '0) begin
                    start  = 1'b1;
                    step_d = 4'd0;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            IDLE: begin
                if (CMD_VALID) begin
                    rdy_d = 1'b0;
                    x_nib = 1'b0;
                    case (OP)
                        4'd0: begin start = 1'b1; x_code = 8'h01; x_wait = T_LONG; end
                        4'd1: begin start = 1'b1; x_code = DATA; x_rs = 1'b1; x_wait = T_CMD; end
                        4'd2: begin start = 1'b1; x_code = {2'b01, DATA[5:0]}; x_wait = T_CMD; end
                        4'd3: begin start = 1'b1; x_code = {1'b1, DATA[6:0]}; x_wait = T_CMD; end
                        4'd4: begin
                            state_d = EXEC_WAIT;
                            cnt_d   = (DATA == 8'd0) ? '0 : op4_cyc - 32'd1;
                        end
                        4'd5: begin start = 1'b1; x_code = DATA; x_wait = T_CMD; end
                        4'd6: begin start = 1'b1; x_code = 8'h02; x_wait = T_LONG; end
                        default: begin
                            err_d   = 1'b1;
                            state_d = EXEC_WAIT;
                            cnt_d   = '0;
                        end
                    endcase
                end
            end
            XFER_SETUP: begin
                e_d     = 1'b1;
                cnt_d   = T_E - 32'd1;
                state_d = XFER_STROBE;
            end
            XFER_STROBE: begin
                if (cnt_q == '0) begin
                    e_d = 1'b0;
                    // Lower nibble is set up during the gap while E is low.
                    if (NIBBLE_BUS && !nib_q && !half_q) begin
                        half_d  = 1'b1;
                        db_d    = {code_q[3:0], 4'h0};
                        cnt_d   = T_NIB - 32'd1;
                        state_d = XFER_GAP;
                    end else begin
                        cnt_d   = wait_q - 32'd1;
                        state_d = EXEC_WAIT;
                    end
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            XFER_GAP: begin
                if (cnt_q == '0) begin
                    e_d     = 1'b1;
                    cnt_d   = T_E - 32'd1;
                    state_d = XFER_STROBE;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            EXEC_WAIT: begin
                if (cnt_q == '0) begin
                    if (init_q && step_q != INIT_LAST) begin
                        start  = 1'b1;
                        step_d = next_idx;
                    end else begin
                        init_d  = 1'b0;
                        rdy_d   = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            default: state_d = INIT_WAIT;
        endcase

        if (start) begin
            state_d = XFER_SETUP;
            code_d  = x_code;
            rs_d    = x_rs;
            nib_d   = x_nib;
            wait_d  = x_wait;
            half_d  = 1'b0;
            e_d     = 1'b0;
            db_d    = bus_first(x_code);
        end
    end

    // State and registered outputs; reset aborts any transfer and restarts init.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= INIT_WAIT;
            cnt_q   <= T_PWR - 32'd1;
            wait_q  <= '0;
            step_q  <= '0;
            code_q  <= '0;
            db_q    <= '0;
            init_q  <= 1'b1;
            nib_q   <= 1'b0;
            half_q  <= 1'b0;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
            rs_q    <= 1'b0;
            e_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            step_q  <= step_d;
            code_q  <= code_d;
            db_q    <= db_d;
            init_q  <= init_d;
            nib_q   <= nib_d;
            half_q  <= half_d;
            rdy_q   <= rdy_d;
            err_q   <= err_d;
            rs_q    <= rs_d;
            e_q     <= e_d;
        end
    end

    assign RDY    = rdy_q;
    assign ERR    = err_q;
    assign LCD_RS = rs_q;
    assign LCD_RW = 1'b0;
    assign LCD_E  = e_q;
    assign LCD_DB = db_q;

endmodule

// File: tb/tb_lcd_hd44780_driver.sv
// Directed bench for lcd_hd44780_driver at CLK_HZ=1 MHz: one 8-bit and one
// 4-bit instance; outputs are sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_lcd_hd44780_driver;

    logic       clk = 1'b0;
    logic       rst8, rst4, valid, sel4;
    logic [3:0] op;
    logic [7:0] data;
    logic       v8, v4;
    logic       rdy8, err8, rs8, rw8, e8;
    logic       rdy4, err4, rs4, rw4, e4;
    logic [7:0] db8, db4;
    logic       o_rdy, o_err, o_rs, o_rw, o_e;
    logic [7:0] o_db;

    int unsigned cyc = 0;
    int unsigned base = 0;
    int          errors = 0;
    int          checks = 0;

    int unsigned at8  [7]  = '{15001, 19103, 19205, 19249, 19293, 19337, 20979};
    logic [7:0]  dbv8 [7]  = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    int unsigned at4  [12] = '{15001, 19103, 19205, 19249, 19293, 19295,
                               19339, 19341, 19385, 19387, 21029, 21031};
    logic [7:0]  dbv4 [12] = '{8'h30, 8'h30, 8'h30, 8'h20, 8'h20, 8'h80,
                               8'h00, 8'hC0, 8'h00, 8'h10, 8'h00, 8'h60};

    always #500 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign v8    = valid & ~sel4;
    assign v4    = valid & sel4;
    assign o_rdy = sel4 ? rdy4 : rdy8;
    assign o_err = sel4 ? err4 : err8;
    assign o_rs  = sel4 ? rs4  : rs8;
    assign o_rw  = sel4 ? rw4  : rw8;
    assign o_e   = sel4 ? e4   : e8;
    assign o_db  = sel4 ? db4  : db8;

    lcd_hd44780_driver #(.CLK_HZ(1_000_000), .BUS_WIDTH(8), .LINES(2)) dut8 (
        .CLK(clk), .RST(rst8), .CMD_VALID(v8), .OP(op), .DATA(data),
        .RDY(rdy8), .ERR(err8), .LCD_RS(rs8), .LCD_RW(rw8), .LCD_E(e8), .LCD_DB(db8));

    lcd_hd44780_driver #(.CLK_HZ(1_000_000), .BUS_WIDTH(4), .LINES(2)) dut4 (
        .CLK(clk), .RST(rst4), .CMD_VALID(v4), .OP(op), .DATA(data),
        .RDY(rdy4), .ERR(err4), .LCD_RS(rs4), .LCD_RW(rw4), .LCD_E(e4), .LCD_DB(db4));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic outs_zero(input string tag);
        chk({tag, "_rdy"}, o_rdy, 0);
        chk({tag, "_err"}, o_err, 0);
        chk({tag, "_rs"},  o_rs,  0);
        chk({tag, "_rw"},  o_rw,  0);
        chk({tag, "_e"},   o_e,   0);
        chk({tag, "_db"},  o_db,  0);
    endtask

    // Edge number (since reset release) of the next E rising edge.
    task automatic wait_rise(input int unsigned budget, output int unsigned at);
        logic prev;
        bit   found;
        prev  = o_e;
        found = 0;
        at    = 0;
        for (int unsigned i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (o_e && !prev) begin
                found = 1;
                at    = cyc - base;
            end
            prev = o_e;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL e_rise_timeout: no E rising edge within %0d cycles", budget);
        end
    endtask

    // Cycles from now until RDY returns, plus how many of them had E high.
    task automatic wait_rdy(input string tag, input int unsigned budget,
                            input int unsigned exp_n, input int unsigned exp_ehi);
        int unsigned n;
        int unsigned ehi;
        n   = 0;
        ehi = 0;
        while (!o_rdy && n < budget) begin
            @(negedge clk);
            n++;
            if (o_e) ehi++;
        end
        chk({tag, "_rdy_cycles"}, n, exp_n);
        chk({tag, "_e_high"}, ehi, exp_ehi);
    endtask

    task automatic run_init(input bit four);
        int unsigned at;
        int unsigned n;
        int unsigned rdy_at;
        @(negedge clk);
        if (four) rst4 = 1'b1; else rst8 = 1'b1;
        base = cyc;
        repeat (15000) @(negedge clk);
        chk("init_rdy_low", o_rdy, 0);
        chk("init_e_low", o_e, 0);
        n      = four ? 12 : 7;
        rdy_at = four ? 21074 : 21022;
        for (int i = 0; i < n; i++) begin
            wait_rise(5000, at);
            chk($sformatf("init_at%0d", i), at, four ? at4[i] : at8[i]);
            chk($sformatf("init_db%0d", i), o_db, four ? dbv4[i] : dbv8[i]);
            chk($sformatf("init_rs%0d", i), o_rs, 0);
        end
        while ((cyc - base) < rdy_at - 1) @(negedge clk);
        chk("init_rdy_before", o_rdy, 0);
        @(negedge clk);
        chk("init_rdy_after", o_rdy, 1);
    endtask

    // Present one command; returns on the falling edge after acceptance.
    task automatic send(input logic [3:0] o, input logic [7:0] d);
        valid = 1'b1;
        op    = o;
        data  = d;
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic byte_cmd(input string tag, input logic [3:0] o, input logic [7:0] d,
                            input logic [7:0] exp_db, input logic exp_rs, input int unsigned exp_n);
        send(o, d);
        chk({tag, "_rdy0"}, o_rdy, 0);
        chk({tag, "_db"}, o_db, exp_db);
        chk({tag, "_rs"}, o_rs, exp_rs);
        wait_rdy(tag, 5000, exp_n, 1);
    endtask

    initial begin
        rst8  = 1'b0;
        rst4  = 1'b0;
        valid = 1'b0;
        sel4  = 1'b0;
        op    = '0;
        data  = '0;
        repeat (3) @(negedge clk);
        outs_zero("rst8");

        run_init(1'b0);

        // OP1 with CMD_VALID held and OP/DATA changed while busy.
        valid = 1'b1;
        op    = 4'd1;
        data  = 8'h41;
        @(negedge clk);
        op   = 4'd0;
        data = 8'h99;
        chk("op1_rdy0", o_rdy, 0);
        chk("op1_rs", o_rs, 1);
        chk("op1_db_setup", o_db, 8'h41);
        chk("op1_e_setup", o_e, 0);
        @(negedge clk);
        chk("op1_e_high", o_e, 1);
        chk("op1_db_strobe", o_db, 8'h41);
        @(negedge clk);
        chk("op1_e_low", o_e, 0);
        begin
            int unsigned ehi = 0;
            repeat (41) begin
                @(negedge clk);
                if (o_e) ehi++;
            end
            chk("op1_held_rdy_low", o_rdy, 0);
            valid = 1'b0;
            @(negedge clk);
            chk("op1_rdy_back", o_rdy, 1);
            chk("op1_no_second_e", ehi, 0);
            chk("op1_db_latched", o_db, 8'h41);
        end

        byte_cmd("op3", 4'd3, 8'hC5, 8'hC5, 1'b0, 44);
        byte_cmd("op2", 4'd2, 8'hFF, 8'h7F, 1'b0, 44);
        byte_cmd("op5", 4'd5, 8'h33, 8'h33, 1'b0, 44);
        byte_cmd("op6", 4'd6, 8'h00, 8'h02, 1'b0, 1642);

        send(4'd4, 8'd3);
        chk("op4_3_rdy0", o_rdy, 0);
        wait_rdy("op4_3", 5000, 3000, 0);

        send(4'd4, 8'd0);
        chk("op4_0_rdy0", o_rdy, 0);
        wait_rdy("op4_0", 10, 1, 0);

        send(4'd9, 8'h00);
        chk("op9_err", o_err, 1);
        chk("op9_rdy0", o_rdy, 0);
        wait_rdy("op9", 10, 1, 0);
        chk("op9_err_cleared", o_err, 0);

        // Reset while the OP0 strobe is high.
        send(4'd0, 8'h00);
        chk("op0_db", o_db, 8'h01);
        @(negedge clk);
        chk("op0_e_high", o_e, 1);
        rst8 = 1'b0;
        #1;
        outs_zero("midrst");
        run_init(1'b0);

        sel4 = 1'b1;
        @(negedge clk);
        outs_zero("rst4");
        run_init(1'b1);

        send(4'd1, 8'h5A);
        chk("nib_db_hi_setup", o_db, 8'h50);
        chk("nib_rs", o_rs, 1);
        chk("nib_e_setup", o_e, 0);
        @(negedge clk);
        chk("nib_e1", o_e, 1);
        chk("nib_db_hi", o_db, 8'h50);
        @(negedge clk);
        chk("nib_gap_e", o_e, 0);
        chk("nib_db_lo_gap", o_db, 8'hA0);
        @(negedge clk);
        chk("nib_e2", o_e, 1);
        chk("nib_db_lo", o_db, 8'hA0);
        @(negedge clk);
        chk("nib_e_end", o_e, 0);
        wait_rdy("nib", 200, 42, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
